// File: rtl/vproc_result_store_pkg.sv
// Shared types for the vector result writeback sequencer.
package vproc_result_store_pkg;

  typedef enum logic [1:0] {
    EMUL_1 = 2'd0,
    EMUL_2 = 2'd1,
    EMUL_4 = 2'd2,
    EMUL_8 = 2'd3
  } cfg_emul;

  typedef struct packed {
    logic       vreg;
    logic       narrow;
    logic       first;
    logic       last;
    logic [4:0] base_addr;
    cfg_emul    emul;
  } result_store_info;

  typedef enum logic [1:0] {
    RS_IDLE  = 2'd0,
    RS_ACCUM = 2'd1,
    RS_WRITE = 2'd2
  } res_store_state;

endpackage

// File: rtl/vproc_result_store_pack.sv
// Lane packer: places full- or half-width result beats into a register-wide
// data/byte-enable buffer, filling from the LSB.
module vproc_res_pack #(
  parameter int unsigned VREG_W = 128,
  parameter int unsigned RES_W  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_place,
  input  logic                  i_restart,
  input  logic                  i_narrow,
  input  logic [RES_W-1:0]      i_data,
  input  logic [RES_W/8-1:0]    i_be,
  input  logic                  i_clear,
  output logic [VREG_W-1:0]     o_data,
  output logic [VREG_W/8-1:0]   o_be,
  output logic                  o_fills
);

  localparam int unsigned N  = VREG_W / RES_W;
  localparam int unsigned CW = $clog2(2 * N) + 1;

  logic [CW-1:0]       r_cnt;
  logic [VREG_W-1:0]   r_data;
  logic [VREG_W/8-1:0] r_be;

  logic [CW-1:0]       w_k;
  logic [CW-1:0]       w_limit;
  logic [31:0]         w_dshift;
  logic [31:0]         w_bshift;
  logic [VREG_W-1:0]   w_lane_data;
  logic [VREG_W/8-1:0] w_lane_be;

  always_comb begin
    w_k      = i_restart ? '0 : r_cnt;
    w_limit  = i_narrow ? CW'(2 * N) : CW'(N);
    o_fills  = i_place && ((w_k + CW'(1)) == w_limit);
    w_dshift = 32'(w_k) * (i_narrow ? 32'(RES_W / 2)  : 32'(RES_W));
    w_bshift = 32'(w_k) * (i_narrow ? 32'(RES_W / 16) : 32'(RES_W / 8));
    w_lane_data = i_narrow ? VREG_W'(i_data[RES_W/2-1:0]) : VREG_W'(i_data);
    w_lane_be   = i_narrow ? (VREG_W/8)'(i_be[RES_W/16-1:0]) : (VREG_W/8)'(i_be);
  end

  // Each lane is written once per fill, so OR-ing into a cleared buffer is exact.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_cnt  <= '0;
      r_data <= '0;
      r_be   <= '0;
    end else if (i_place) begin
      r_cnt  <= w_k + CW'(1);
      r_data <= (i_restart ? '0 : r_data) | (w_lane_data << w_dshift);
      r_be   <= (i_restart ? '0 : r_be)   | (w_lane_be << w_bshift);
    end
  end

  assign o_data = r_data;
  assign o_be   = r_be;

endmodule

// File: rtl/vproc_result_store.sv
// Result writeback sequencer: packs unit result beats into vreg words, steps
// across the EMUL group, writes the register file and clears pending hazards.
module vproc_result_store
  import vproc_result_store_pkg::*;
#(
  parameter int unsigned VREG_W = 128,
  parameter int unsigned RES_W  = 32
) (
  input  logic                clk_i,
  input  logic                sync_rst_i,
  input  logic                res_valid_i,
  output logic                res_ready_o,
  input  logic                res_first_i,
  input  logic                res_last_i,
  input  logic                res_vreg_i,
  input  logic                res_narrow_i,
  input  logic [4:0]          res_base_addr_i,
  input  logic [1:0]          res_emul_i,
  input  logic [RES_W-1:0]    res_data_i,
  input  logic [RES_W/8-1:0]  res_be_i,
  output logic                vreg_wr_en_o,
  input  logic                vreg_wr_ready_i,
  output logic [4:0]          vreg_wr_addr_o,
  output logic [VREG_W-1:0]   vreg_wr_data_o,
  output logic [VREG_W/8-1:0] vreg_wr_be_o,
  output logic [31:0]         clear_hazard_o,
  output logic                xreg_valid_o,
  output logic [31:0]         xreg_data_o,
  output logic                error_o
);

  res_store_state   r_state, w_state_nxt;
  result_store_info r_info;
  logic [3:0]       r_mul;
  logic             r_error;
  logic             r_xreg_valid;
  logic [31:0]      r_xreg_data;

  logic       w_acc, w_vbeat, w_restart, w_over, w_place, w_fills, w_to_write, w_grant;
  logic       w_narrow;
  logic [3:0] w_mul_eff;
  logic [1:0] w_emul_eff;

  assign res_ready_o = (r_state != RS_WRITE);
  assign w_acc       = res_valid_i && res_ready_o;
  assign w_vbeat     = w_acc && res_vreg_i;
  assign w_restart   = w_vbeat && res_first_i;
  assign w_mul_eff   = w_restart ? 4'd0 : r_mul;
  assign w_emul_eff  = w_restart ? res_emul_i : r_info.emul;
  assign w_narrow    = w_restart ? res_narrow_i : r_info.narrow;
  assign w_over      = w_vbeat && (w_mul_eff == (4'd1 << w_emul_eff));
  assign w_place     = w_vbeat && !w_over;
  assign w_to_write  = w_place && (w_fills || res_last_i);
  assign w_grant     = (r_state == RS_WRITE) && vreg_wr_ready_i && !sync_rst_i;

  vproc_res_pack #(
    .VREG_W (VREG_W),
    .RES_W  (RES_W)
  ) u_pack (
    .i_clk     (clk_i),
    .i_rst     (sync_rst_i),
    .i_place   (w_place),
    .i_restart (w_restart),
    .i_narrow  (w_narrow),
    .i_data    (res_data_i),
    .i_be      (res_be_i),
    .i_clear   (w_grant),
    .o_data    (vreg_wr_data_o),
    .o_be      (vreg_wr_be_o),
    .o_fills   (w_fills)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RS_IDLE, RS_ACCUM: begin
        if (w_to_write)                        w_state_nxt = RS_WRITE;
        else if (w_vbeat && w_over && res_last_i) w_state_nxt = RS_IDLE;
        else if (w_place)                      w_state_nxt = RS_ACCUM;
      end
      RS_WRITE: begin
        if (w_grant) w_state_nxt = r_info.last ? RS_IDLE : RS_ACCUM;
      end
      default: w_state_nxt = RS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      r_state      <= RS_IDLE;
      r_info       <= '0;
      r_mul        <= '0;
      r_error      <= 1'b0;
      r_xreg_valid <= 1'b0;
      r_xreg_data  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_xreg_valid <= w_acc && !res_vreg_i && res_last_i;
      if (w_acc && !res_vreg_i && res_last_i) r_xreg_data <= res_data_i[31:0];
      if (w_restart) begin
        r_info <= '{vreg: res_vreg_i, narrow: res_narrow_i, first: 1'b1, last: res_last_i,
                    base_addr: res_base_addr_i, emul: cfg_emul'(res_emul_i)};
        r_mul  <= '0;
      end
      // The final NBA decides whether the pending write closes the instruction.
      if (w_to_write) r_info.last <= res_last_i;
      if (w_grant)    r_mul <= r_mul + 4'd1;
      if (w_over || (w_restart && r_state == RS_ACCUM)) r_error <= 1'b1;
    end
  end

  assign vreg_wr_en_o   = (r_state == RS_WRITE);
  assign vreg_wr_addr_o = r_info.base_addr | {2'b00, r_mul[2:0]};
  assign clear_hazard_o = w_grant ? (32'd1 << vreg_wr_addr_o) : '0;
  assign xreg_valid_o   = r_xreg_valid;
  assign xreg_data_o    = r_xreg_data;
  assign error_o        = r_error;

endmodule

// File: tb/tb_vproc_result_store.sv
// Directed bench for vproc_result_store with hand-computed expected writes.
module tb_vproc_result_store;

  logic         clk_i = 1'b0;
  logic         sync_rst_i = 1'b1;
  logic         res_valid_i = 1'b0;
  logic         res_ready_o;
  logic         res_first_i = 1'b0;
  logic         res_last_i = 1'b0;
  logic         res_vreg_i = 1'b1;
  logic         res_narrow_i = 1'b0;
  logic [4:0]   res_base_addr_i = '0;
  logic [1:0]   res_emul_i = '0;
  logic [31:0]  res_data_i = '0;
  logic [3:0]   res_be_i = '0;
  logic         vreg_wr_en_o;
  logic         vreg_wr_ready_i = 1'b0;
  logic [4:0]   vreg_wr_addr_o;
  logic [127:0] vreg_wr_data_o;
  logic [15:0]  vreg_wr_be_o;
  logic [31:0]  clear_hazard_o;
  logic         xreg_valid_o;
  logic [31:0]  xreg_data_o;
  logic         error_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned n_clr = 0;

  vproc_result_store #(
    .VREG_W (128),
    .RES_W  (32)
  ) dut (
    .clk_i           (clk_i),
    .sync_rst_i      (sync_rst_i),
    .res_valid_i     (res_valid_i),
    .res_ready_o     (res_ready_o),
    .res_first_i     (res_first_i),
    .res_last_i      (res_last_i),
    .res_vreg_i      (res_vreg_i),
    .res_narrow_i    (res_narrow_i),
    .res_base_addr_i (res_base_addr_i),
    .res_emul_i      (res_emul_i),
    .res_data_i      (res_data_i),
    .res_be_i        (res_be_i),
    .vreg_wr_en_o    (vreg_wr_en_o),
    .vreg_wr_ready_i (vreg_wr_ready_i),
    .vreg_wr_addr_o  (vreg_wr_addr_o),
    .vreg_wr_data_o  (vreg_wr_data_o),
    .vreg_wr_be_o    (vreg_wr_be_o),
    .clear_hazard_o  (clear_hazard_o),
    .xreg_valid_o    (xreg_valid_o),
    .xreg_data_o     (xreg_data_o),
    .error_o         (error_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (clear_hazard_o != 32'd0) n_clr++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_beat(input logic f, input logic l, input logic v, input logic n,
                           input logic [4:0] base, input logic [1:0] emul,
                           input logic [31:0] d, input logic [3:0] be);
    int unsigned t = 0;
    while (!res_ready_o && t < 20) begin tick(); t++; end
    if (!res_ready_o) chk("beat_ready_timeout", 128'(res_ready_o), 128'd1);
    res_valid_i = 1'b1; res_first_i = f; res_last_i = l; res_vreg_i = v;
    res_narrow_i = n; res_base_addr_i = base; res_emul_i = emul;
    res_data_i = d; res_be_i = be;
    tick();
    res_valid_i = 1'b0; res_first_i = 1'b0; res_last_i = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [4:0] a, input logic [127:0] d,
                              input logic [15:0] be, input int unsigned hold);
    int unsigned t = 0;
    int unsigned c0 = n_clr;
    while (!vreg_wr_en_o && t < 20) begin tick(); t++; end
    for (int unsigned i = 0; i <= hold; i++) begin
      chk({tag, "_en"},    128'(vreg_wr_en_o), 128'd1);
      chk({tag, "_addr"},  128'(vreg_wr_addr_o), 128'(a));
      chk({tag, "_data"},  vreg_wr_data_o, d);
      chk({tag, "_be"},    128'(vreg_wr_be_o), 128'(be));
      chk({tag, "_rdy0"},  128'(res_ready_o), 128'd0);
      chk({tag, "_noclr"}, 128'(clear_hazard_o), 128'd0);
      if (i < hold) tick();
    end
    vreg_wr_ready_i = 1'b1;
    #1;
    chk({tag, "_clr"}, 128'(clear_hazard_o), 128'(32'd1 << a));
    tick();
    vreg_wr_ready_i = 1'b0;
    chk({tag, "_clr_end"}, 128'(clear_hazard_o), 128'd0);
    chk({tag, "_en_end"},  128'(vreg_wr_en_o), 128'd0);
    chk({tag, "_npulse"},  128'(n_clr - c0), 128'd1);
  endtask

  initial begin
    int unsigned c0;
    repeat (2) tick();
    sync_rst_i = 1'b0;
    chk("rst_wr_en", 128'(vreg_wr_en_o), 128'd0);
    chk("rst_ready", 128'(res_ready_o), 128'd1);
    chk("rst_clr",   128'(clear_hazard_o), 128'd0);
    chk("rst_xreg",  128'(xreg_valid_o), 128'd0);
    chk("rst_err",   128'(error_o), 128'd0);
    chk("rst_data",  vreg_wr_data_o, 128'd0);

    // EMUL_1, four full beats
    for (int i = 1; i <= 4; i++)
      send_beat(i == 1, i == 4, 1'b1, 1'b0, 5'd8, 2'd0, 32'h11111111 * i, 4'hF);
    expect_write("e1", 5'd8, 128'h44444444_33333333_22222222_11111111, 16'hFFFF, 0);
    chk("e1_ready_after", 128'(res_ready_o), 128'd1);

    // EMUL_2, eight beats across two registers
    for (int i = 1; i <= 4; i++)
      send_beat(i == 1, 1'b0, 1'b1, 1'b0, 5'd8, 2'd1, 32'(i), 4'hF);
    expect_write("e2a", 5'd8, 128'h00000004_00000003_00000002_00000001, 16'hFFFF, 1);
    for (int i = 5; i <= 8; i++)
      send_beat(1'b0, i == 8, 1'b1, 1'b0, 5'd8, 2'd1, 32'(i), 4'hF);
    expect_write("e2b", 5'd9, 128'h00000008_00000007_00000006_00000005, 16'hFFFF, 0);

    // Narrow: only low halves of data and be are used
    for (int i = 1; i <= 8; i++)
      send_beat(i == 1, i == 8, 1'b1, 1'b1, 5'd4, 2'd0, 32'h5555AAAA, 4'hF);
    expect_write("nar", 5'd4, {8{16'hAAAA}}, 16'hFFFF, 0);

    // Early last and back-pressured write port
    send_beat(1'b1, 1'b0, 1'b1, 1'b0, 5'd16, 2'd0, 32'hCAFEF00D, 4'hF);
    send_beat(1'b0, 1'b1, 1'b1, 1'b0, 5'd16, 2'd0, 32'h12345678, 4'hF);
    expect_write("part", 5'd16, 128'h00000000_00000000_12345678_CAFEF00D, 16'h00FF, 3);

    // Scalar result
    c0 = n_clr;
    send_beat(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 32'hDEADBEEF, 4'hF);
    chk("x_valid", 128'(xreg_valid_o), 128'd1);
    chk("x_data",  128'(xreg_data_o), 128'hDEADBEEF);
    chk("x_nowr",  128'(vreg_wr_en_o), 128'd0);
    tick();
    chk("x_pulse_end", 128'(xreg_valid_o), 128'd0);
    chk("x_nowr2",     128'(vreg_wr_en_o), 128'd0);
    chk("x_noclr",     128'(n_clr - c0), 128'd0);

    // Overflow beyond the EMUL group
    for (int i = 1; i <= 4; i++)
      send_beat(i == 1, 1'b0, 1'b1, 1'b0, 5'd12, 2'd0, 32'(i), 4'hF);
    expect_write("ovf", 5'd12, 128'h00000004_00000003_00000002_00000001, 16'hFFFF, 0);
    chk("ovf_err0", 128'(error_o), 128'd0);
    send_beat(1'b0, 1'b0, 1'b1, 1'b0, 5'd12, 2'd0, 32'h99999999, 4'hF);
    chk("ovf_err1", 128'(error_o), 128'd1);
    tick();
    chk("ovf_nowr",   128'(vreg_wr_en_o), 128'd0);
    chk("ovf_sticky", 128'(error_o), 128'd1);

    // Reset during WRITE
    sync_rst_i = 1'b1; tick(); sync_rst_i = 1'b0;
    chk("rst2_err", 128'(error_o), 128'd0);
    send_beat(1'b1, 1'b0, 1'b1, 1'b0, 5'd20, 2'd0, 32'h1, 4'hF);
    send_beat(1'b0, 1'b1, 1'b1, 1'b0, 5'd20, 2'd0, 32'h2, 4'hF);
    chk("rw_en", 128'(vreg_wr_en_o), 128'd1);
    c0 = n_clr;
    sync_rst_i = 1'b1; tick(); sync_rst_i = 1'b0;
    chk("rw_en0",  128'(vreg_wr_en_o), 128'd0);
    chk("rw_rdy",  128'(res_ready_o), 128'd1);
    chk("rw_data", vreg_wr_data_o, 128'd0);
    vreg_wr_ready_i = 1'b1;
    tick(); tick();
    vreg_wr_ready_i = 1'b0;
    chk("rw_noclr", 128'(n_clr - c0), 128'd0);

    // First while accumulating restarts the packer and flags an error
    send_beat(1'b1, 1'b0, 1'b1, 1'b0, 5'd24, 2'd0, 32'hAAAA0001, 4'hF);
    send_beat(1'b1, 1'b0, 1'b1, 1'b0, 5'd24, 2'd0, 32'hBBBB0001, 4'hF);
    chk("refirst_err", 128'(error_o), 128'd1);
    send_beat(1'b0, 1'b1, 1'b1, 1'b0, 5'd24, 2'd0, 32'hBBBB0002, 4'h3);
    expect_write("refirst", 5'd24, 128'h00000000_00000000_BBBB0002_BBBB0001, 16'h003F, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
